// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: pixel enable, raster counters and sync/blank decodes.
// frame_start is present only when VGA_SYNC_FRAME_PULSE_EN is defined.
interface vga_sync_gen_if;
  logic       pix_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
`ifdef VGA_SYNC_FRAME_PULSE_EN
  logic       frame_start;
`endif

  modport master (
    output pix_tick, pixel_x, pixel_y, hsync, vsync, video_on
`ifdef VGA_SYNC_FRAME_PULSE_EN
    , output frame_start
`endif
  );

  modport slave (
    input pix_tick, pixel_x, pixel_y, hsync, vsync, video_on
`ifdef VGA_SYNC_FRAME_PULSE_EN
    , input frame_start
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA sync generator: divide-by-4 pixel enable, horizontal/vertical raster
// counters and combinational sync/visible decodes, all on clk.
// Optional registered frame_start pulse: define VGA_SYNC_FRAME_PULSE_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic            clk,
  input  logic            reset,
  vga_sync_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       tick;

  // pix_tick is a clock enable only; nothing is clocked by it
  assign tick = (div_q == 2'd3);

  // Next-state for divider and raster counters; counters move only on tick
  always_comb begin
    div_d = div_q + 2'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q < H_MAX) begin
        x_d = x_q + 10'd1;
      end else begin
        x_d = '0;
        if (y_q == V_MAX) y_d = '0;
        else              y_d = y_q + 10'd1;
      end
    end
  end

  // State registers; reset overrides any pending tick
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

`ifdef VGA_SYNC_FRAME_PULSE_EN
  logic fs_q, fs_d;

  // Pulse is launched on the edge that wraps the raster to (0,0)
  always_comb begin
    fs_d = tick && (x_q == H_MAX) && (y_q == V_MAX);
  end

  // frame_start register
  always_ff @(posedge clk) begin
    if (reset) fs_q <= 1'b0;
    else       fs_q <= fs_d;
  end

  assign vga.frame_start = fs_q;
`endif

  assign vga.pix_tick = tick;
  assign vga.pixel_x  = x_q;
  assign vga.pixel_y  = y_q;
  assign vga.hsync    = !((x_q >= HS_START) && (x_q < HS_END));
  assign vga.vsync    = !((y_q >= VS_START) && (y_q < VS_END));
  assign vga.video_on = (x_q < H_VIS) && (y_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for horizontal behaviour
// and a reduced-timing instance (16 x 10 raster) for frame-level behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset_d = 1'b1;
  logic reset_s = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_sync_gen_if d_if ();
  vga_sync_gen_if s_if ();

  vga_sync_gen dut_d (.clk(clk), .reset(reset_d), .vga(d_if));

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (.clk(clk), .reset(reset_s), .vga(s_if));

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
  } vec_t;

  vec_t dtab[9];
  vec_t stab[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rx(input bit sm);
    return sm ? int'(s_if.pixel_x) : int'(d_if.pixel_x);
  endfunction
  function automatic int ry(input bit sm);
    return sm ? int'(s_if.pixel_y) : int'(d_if.pixel_y);
  endfunction
  function automatic bit rt(input bit sm);
    return sm ? s_if.pix_tick : d_if.pix_tick;
  endfunction

  // Advance to the first negedge where the raster sits at (x,y) (and tick if asked)
  task automatic wait_xy(input bit sm, input int x, input int y, input bit need_tick,
                         input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx(sm) == x && ry(sm) == y && (!need_tick || rt(sm))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_xy: position (%0d,%0d) not reached, at (%0d,%0d)", x, y, rx(sm), ry(sm));
    end
  endtask

  // After reset release: tick in cycles 3,7,11; pixel_x = n/4 after edge n
  task automatic check_release(input bit sm, input string tag);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check({tag, " tick"}, int'(rt(sm)), (n % 4 == 3) ? 1 : 0);
      check({tag, " x"}, rx(sm), n / 4);
    end
  endtask

  task automatic check_vec(input bit sm, input vec_t v, input int idx);
    string tag;
    tag = $sformatf("%s vec%0d (%0d,%0d)", sm ? "s" : "d", idx, v.x, v.y);
    if (sm) begin
      check({tag, " hsync"}, int'(s_if.hsync), int'(v.hs));
      check({tag, " vsync"}, int'(s_if.vsync), int'(v.vs));
      check({tag, " video_on"}, int'(s_if.video_on), int'(v.von));
    end else begin
      check({tag, " hsync"}, int'(d_if.hsync), int'(v.hs));
      check({tag, " vsync"}, int'(d_if.vsync), int'(v.vs));
      check({tag, " video_on"}, int'(d_if.video_on), int'(v.von));
    end
  endtask

  initial begin
    bit ok;
    int hs_low, hs_first_x, fall_n, first_fall, second_fall, vs_low, fall_y;
    bit prev_vs, in_low;
`ifdef VGA_SYNC_FRAME_PULSE_EN
    int fs_n, fs_last;
    bit prev_fs;
`endif

    dtab[0] = '{100, 0, 1, 1, 1};
    dtab[1] = '{639, 0, 1, 1, 1};
    dtab[2] = '{640, 0, 1, 1, 0};
    dtab[3] = '{655, 0, 1, 1, 0};
    dtab[4] = '{656, 0, 0, 1, 0};
    dtab[5] = '{751, 0, 0, 1, 0};
    dtab[6] = '{752, 0, 1, 1, 0};
    dtab[7] = '{799, 0, 1, 1, 0};
    dtab[8] = '{0,   1, 1, 1, 1};

    stab[0] = '{3,  3, 1, 1, 1};
    stab[1] = '{8,  3, 1, 1, 0};
    stab[2] = '{10, 3, 0, 1, 0};
    stab[3] = '{12, 3, 0, 1, 0};
    stab[4] = '{13, 3, 1, 1, 0};
    stab[5] = '{0,  5, 1, 1, 0};
    stab[6] = '{0,  6, 1, 0, 0};
    stab[7] = '{15, 7, 1, 0, 0};
    stab[8] = '{0,  8, 1, 1, 0};

    // Reset state
    repeat (5) @(negedge clk);
    check("rst x", int'(d_if.pixel_x), 0);
    check("rst y", int'(d_if.pixel_y), 0);
    check("rst hsync", int'(d_if.hsync), 1);
    check("rst vsync", int'(d_if.vsync), 1);
    check("rst video_on", int'(d_if.video_on), 1);
    check("rst tick", int'(d_if.pix_tick), 0);

    reset_d = 1'b0;
    check_release(1'b0, "release");

    for (int i = 0; i < 9; i++) begin
      wait_xy(1'b0, dtab[i].x, dtab[i].y, 1'b0, 4000, ok);
      if (ok) check_vec(1'b0, dtab[i], i);
    end

    // hsync low length over line 1
    hs_low = 0;
    hs_first_x = -1;
    for (int i = 0; i < 4000; i++) begin
      if (!d_if.hsync) begin
        if (hs_low == 0) hs_first_x = int'(d_if.pixel_x);
        hs_low++;
      end
      @(negedge clk);
      if (d_if.pixel_x == 10'd0 && d_if.pixel_y == 10'd2) break;
    end
    check("hsync low clk", hs_low, 384);
    check("hsync first x", hs_first_x, 656);

    // Line wrap (799,10) -> (0,11)
    wait_xy(1'b0, 799, 10, 1'b1, 40000, ok);
    @(negedge clk);
    check("wrap x", int'(d_if.pixel_x), 0);
    check("wrap y", int'(d_if.pixel_y), 11);

    // One-cycle reset mid-line while a tick is pending
    wait_xy(1'b0, 300, 11, 1'b1, 4000, ok);
    reset_d = 1'b1;
    @(negedge clk);
    reset_d = 1'b0;
    check("midrst x", int'(d_if.pixel_x), 0);
    check("midrst y", int'(d_if.pixel_y), 0);
    check("midrst hsync", int'(d_if.hsync), 1);
    check("midrst vsync", int'(d_if.vsync), 1);
    check("midrst tick", int'(d_if.pix_tick), 0);
    check_release(1'b0, "midrst resume");

    // Reduced raster: vertical decodes and frame wrap
    reset_s = 1'b0;
    check_release(1'b1, "s release");
    for (int i = 0; i < 9; i++) begin
      wait_xy(1'b1, stab[i].x, stab[i].y, 1'b0, 1000, ok);
      if (ok) check_vec(1'b1, stab[i], i);
    end
    wait_xy(1'b1, 15, 9, 1'b1, 1000, ok);
    @(negedge clk);
    check("s frame wrap x", int'(s_if.pixel_x), 0);
    check("s frame wrap y", int'(s_if.pixel_y), 0);
`ifdef VGA_SYNC_FRAME_PULSE_EN
    check("s frame_start at wrap", int'(s_if.frame_start), 1);
`endif

    // vsync period and width over two-plus frames
    fall_n = 0; first_fall = 0; second_fall = 0; vs_low = 0; fall_y = -1;
    in_low = 1'b0;
    prev_vs = s_if.vsync;
`ifdef VGA_SYNC_FRAME_PULSE_EN
    fs_n = 0; fs_last = 0;
    prev_fs = s_if.frame_start;
`endif
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (prev_vs && !s_if.vsync) begin
        fall_n++;
        if (fall_n == 1) begin
          first_fall = cyc;
          fall_y = int'(s_if.pixel_y);
          in_low = 1'b1;
        end
        if (fall_n == 2) second_fall = cyc;
      end
      if (in_low) begin
        if (s_if.vsync) in_low = 1'b0;
        else vs_low++;
      end
      prev_vs = s_if.vsync;
`ifdef VGA_SYNC_FRAME_PULSE_EN
      if (s_if.frame_start) begin
        check("s frame_start width", int'(prev_fs), 0);
        check("s frame_start x", int'(s_if.pixel_x), 0);
        check("s frame_start y", int'(s_if.pixel_y), 0);
        if (fs_n > 0) check("s frame_start period", cyc - fs_last, 640);
        fs_n++;
        fs_last = cyc;
      end
      prev_fs = s_if.frame_start;
`endif
    end
    check("s vsync falls", (fall_n >= 2) ? 1 : 0, 1);
    check("s vsync period", second_fall - first_fall, 640);
    check("s vsync low clk", vs_low, 128);
    check("s vsync fall y", fall_y, 6);
`ifdef VGA_SYNC_FRAME_PULSE_EN
    check("s frame_start count", (fs_n >= 2) ? 1 : 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, system clock (100 MHz); the only clock in the block
- reset, input, 1, synchronous, active-high reset
- pix_tick, output, 1, one-clk-wide pixel enable, asserted once every 4 clk cycles
- pixel_x, output, 10, current horizontal count, 0..H_TOTAL-1
- pixel_y, output, 10, current vertical count, 0..V_TOTAL-1
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- video_on, output, 1, high while (pixel_x, pixel_y) is inside the visible area
- frame_start, output, 1, one-clk pulse at frame wrap; present only with VGA_SYNC_FRAME_PULSE_EN
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Function
REQ-004 A 2-bit divider increments on every clk edge with reset low and wraps 3->0; pix_tick is the combinational decode divider==3.
REQ-005 All logic runs on clk; pix_tick is used only as a clock enable, and no divided clock is generated or used as a clock.
REQ-006 On a clk edge with pix_tick=1: if pixel_x<H_TOTAL-1, pixel_x increments; otherwise pixel_x becomes 0.
REQ-007 On an edge where pixel_x wraps: pixel_y increments, or becomes 0 if pixel_y==V_TOTAL-1.
REQ-008 Counters hold their value on every edge with pix_tick=0.
REQ-009 hsync=0 iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-010 vsync=0 iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-011 video_on=1 iff pixel_x<H_ACTIVE and pixel_y<V_ACTIVE.
REQ-012 hsync, vsync and video_on are combinational decodes of the registered counters, with zero latency relative to pixel_x and pixel_y.
REQ-013 Line period is 800 ticks (3200 clk); frame period is 420000 ticks (1,680,000 clk).

Reset
REQ-014 While reset=1 at a clk edge: divider=0, pixel_x=0, pixel_y=0 (and frame_start=0 if compiled in); therefore hsync=1, vsync=1, video_on=1, pix_tick=0.
REQ-015 Reset asserted mid-frame takes effect on the next clk edge regardless of divider or counter state; reset has priority over pix_tick.
REQ-016 After reset release, the first pix_tick occurs in the clk cycle following the 3rd edge with reset low; pixel_x reads 1 after the 4th edge.

Configuration
REQ-017 Macro VGA_SYNC_FRAME_PULSE_EN.
- Defined: frame_start port exists and is a registered output; it is 1 for exactly one clk cycle, the cycle immediately after the edge on which counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0); it is 0 otherwise.
- Undefined: port and its logic are absent; all other behaviour is identical.

Verification
REQ-018 Hold reset 5 clk, then release -> pix_tick high only in cycle 4 after release and every 4th cycle thereafter; pixel_x=1 after edge 4.
REQ-019 Run one line -> hsync low for exactly 384 clk, beginning when pixel_x becomes 656; video_on falls when pixel_x becomes 640.
REQ-020 pixel_x=799, pixel_y=10, pix_tick=1 -> next edge: pixel_x=0, pixel_y=11; (799,524) -> (0,0).
REQ-021 Run two frames -> vsync low for 6400 clk starting at pixel_y=490; vsync falling edges are 1,680,000 clk apart.
REQ-022 Assert reset for 1 clk at pixel_x=300, pixel_y=200 -> next edge: counters 0, divider 0, hsync=1, vsync=1; normal counting resumes per REQ-016.
REQ-023 With VGA_SYNC_FRAME_PULSE_EN defined -> frame_start high for 1 clk, 1,680,000 clk apart, coincident with (0,0); with it undefined -> design elaborates without the port.
